// File: rtl/mdu.sv
// Multiply/divide unit: fixed-latency mult/multu/div/divu with architectural
// HI/LO, plus mthi/mtlo writes and mfhi/mflo reads for the E stage.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] mdu_rd
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   hi_t_q, hi_t_d, lo_t_q, lo_t_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          commit_en_q, commit_en_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, divisor_u, divisor_s;
    logic [31:0] quot_u, rem_u, quot_m, rem_m, quot_s, rem_s;
    logic        accept;

    // Signed divide works on magnitudes; this also yields the required
    // 0x80000000 / -1 result without a special case.
    always_comb begin
        prod_s    = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u    = {32'd0, A} * {32'd0, B};
        a_mag     = A[31] ? (~A + 32'd1) : A;
        b_mag     = B[31] ? (~B + 32'd1) : B;
        divisor_u = (B == 32'd0) ? 32'd1 : B;
        divisor_s = (b_mag == 32'd0) ? 32'd1 : b_mag;
        quot_u    = A / divisor_u;
        rem_u     = A % divisor_u;
        quot_m    = a_mag / divisor_s;
        rem_m     = a_mag % divisor_s;
        quot_s    = (A[31] ^ B[31]) ? (~quot_m + 32'd1) : quot_m;
        rem_s     = A[31] ? (~rem_m + 32'd1) : rem_m;
    end

    // A new operation may start when idle or on the commit edge (cnt = 1).
    assign accept = start && (mdu_op >= OP_MULT) && (mdu_op <= OP_DIVU) && (cnt_q <= CNT_ONE);

    always_comb begin
        hi_d        = hi_q;
        lo_d        = lo_q;
        hi_t_d      = hi_t_q;
        lo_t_d      = lo_t_q;
        cnt_d       = cnt_q;
        commit_en_d = commit_en_q;

        if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
            if ((cnt_q == CNT_ONE) && commit_en_q) begin
                hi_d = hi_t_q;
                lo_d = lo_t_q;
            end
        end else begin
            if (mdu_op == OP_MTHI) hi_d = A;
            if (mdu_op == OP_MTLO) lo_d = A;
        end

        if (accept) begin
            case (mdu_op)
                OP_MULT: begin
                    hi_t_d      = prod_s[63:32];
                    lo_t_d      = prod_s[31:0];
                    cnt_d       = MULT_LOAD;
                    commit_en_d = 1'b1;
                end
                OP_MULTU: begin
                    hi_t_d      = prod_u[63:32];
                    lo_t_d      = prod_u[31:0];
                    cnt_d       = MULT_LOAD;
                    commit_en_d = 1'b1;
                end
                OP_DIV: begin
                    hi_t_d      = rem_s;
                    lo_t_d      = quot_s;
                    cnt_d       = DIV_LOAD;
                    commit_en_d = (B != 32'd0);
                end
                default: begin
                    hi_t_d      = rem_u;
                    lo_t_d      = quot_u;
                    cnt_d       = DIV_LOAD;
                    commit_en_d = (B != 32'd0);
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q        <= '0;
            lo_q        <= '0;
            hi_t_q      <= '0;
            lo_t_q      <= '0;
            cnt_q       <= '0;
            commit_en_q <= 1'b0;
        end else begin
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            hi_t_q      <= hi_t_d;
            lo_t_q      <= lo_t_d;
            cnt_q       <= cnt_d;
            commit_en_q <= commit_en_d;
        end
    end

    always_comb begin
        mdu_rd = 32'd0;
        if (mdu_op == OP_MFHI) mdu_rd = hi_q;
        if (mdu_op == OP_MFLO) mdu_rd = lo_q;
    end

    assign busy = (cnt_q != '0);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases plus randomized operations
// compared against an arithmetic reference model of HI/LO.
module tb_mdu;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  mdu_op;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] mdu_rd;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   mdu #(
      .MULT_CYCLES(MC),
      .DIV_CYCLES (DC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .mdu_op(mdu_op),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .HI    (HI),
      .LO    (LO),
      .mdu_rd(mdu_rd)
   );

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   // Drive all DUT inputs at once
   task automatic applyStimulus(input bit s, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      start  = s;
      mdu_op = op;
      A      = a;
      B      = b;
   endtask

   // Single comparison point; counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Expected mfhi/mflo read-port value from the architectural model
   function automatic logic [31:0] expRd(input logic [3:0] op);
      if (op == 4'd5) return m_hi;
      if (op == 4'd6) return m_lo;
      return 32'd0;
   endfunction

   // Reference arithmetic straight from the instruction definitions
   task automatic refCompute(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             output bit commit, output logic [31:0] h, output logic [31:0] l);
      int sa;
      int sb;
      longint p;
      longint unsigned up;
      sa = a;
      sb = b;
      commit = 1'b1;
      h = 32'd0;
      l = 32'd0;
      case (op)
         4'd1: begin
            p = longint'(sa) * longint'(sb);
            h = p[63:32];
            l = p[31:0];
         end
         4'd2: begin
            up = longint'({32'd0, a}) * longint'({32'd0, b});
            h = up[63:32];
            l = up[31:0];
         end
         4'd3: begin
            if (b == 32'd0) commit = 1'b0;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               l = 32'h8000_0000;
               h = 32'd0;
            end else begin
               l = sa / sb;
               h = sa % sb;
            end
         end
         default: begin
            if (b == 32'd0) commit = 1'b0;
            else begin
               l = a / b;
               h = a % b;
            end
         end
      endcase
   endtask

   // Issue one mult/div at a negedge and follow it through its busy window,
   // optionally throwing ignored traffic at the unit while it is busy
   task automatic runOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit intrude);
      bit ce;
      logic [31:0] eh;
      logic [31:0] el;
      int n;
      refCompute(op, a, b, ce, eh, el);
      n = (op <= 4'd2) ? MC : DC;
      applyStimulus(1'b1, op, a, b);
      @(posedge clk);
      @(negedge clk);
      for (int i = 1; i <= n; i++) begin
         if (intrude && i < n) begin
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 8)), $urandom, $urandom);
            #1;
            checkOutput("rd_while_busy", mdu_rd, expRd(mdu_op));
         end else begin
            applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
         end
         checkOutput("busy_high", {31'd0, busy}, 32'd1);
         checkOutput("hi_hold", HI, m_hi);
         checkOutput("lo_hold", LO, m_lo);
         @(posedge clk);
         @(negedge clk);
      end
      applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
      if (ce) begin
         m_hi = eh;
         m_lo = el;
      end
      checkOutput("busy_done", {31'd0, busy}, 32'd0);
      checkOutput("hi_result", HI, m_hi);
      checkOutput("lo_result", LO, m_lo);
   endtask

   // mthi/mtlo while idle
   task automatic doMove(input logic [3:0] op, input logic [31:0] a);
      applyStimulus(1'b0, op, a, $urandom);
      @(posedge clk);
      @(negedge clk);
      if (op == 4'd7) m_hi = a;
      else m_lo = a;
      applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
      checkOutput("move_hi", HI, m_hi);
      checkOutput("move_lo", LO, m_lo);
   endtask

   // Read-port check for any non-arithmetic op, then confirm no state change
   task automatic doRead(input logic [3:0] op, input bit s);
      applyStimulus(s, op, $urandom, $urandom);
      #1;
      checkOutput("read_port", mdu_rd, expRd(op));
      @(posedge clk);
      @(negedge clk);
      applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
      checkOutput("read_busy", {31'd0, busy}, 32'd0);
      checkOutput("read_hi", HI, m_hi);
      checkOutput("read_lo", LO, m_lo);
   endtask

   initial begin
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;

      reset = 1'b1;
      applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_hi", HI, 32'd0);
      checkOutput("reset_lo", LO, 32'd0);
      checkOutput("reset_rd", mdu_rd, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] directed operations");
      runOp(4'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
      runOp(4'd2, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
      runOp(4'd3, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
      runOp(4'd4, 32'd100, 32'd7, 1'b0);
      runOp(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      doMove(4'd7, 32'h11);
      doMove(4'd8, 32'h22);
      runOp(4'd4, 32'd5, 32'd0, 1'b0);
      runOp(4'd3, 32'd9, 32'd0, 1'b0);
      doMove(4'd7, 32'h1234_5678);
      doRead(4'd5, 1'b0);
      doRead(4'd6, 1'b0);
      doRead(4'd0, 1'b1);
      runOp(4'd1, 32'd1000, 32'hFFFF_FFFD, 1'b1);

      $display("[TB] back-to-back start on the commit edge");
      applyStimulus(1'b1, 4'd1, 32'd3, 32'd4);
      @(posedge clk);
      @(negedge clk);
      for (int i = 1; i <= MC; i++) begin
         if (i == MC) applyStimulus(1'b1, 4'd4, 32'd100, 32'd7);
         else applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
         checkOutput("b2b_first_busy", {31'd0, busy}, 32'd1);
         @(posedge clk);
         @(negedge clk);
      end
      applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
      m_hi = 32'd0;
      m_lo = 32'd12;
      for (int i = 1; i <= DC; i++) begin
         checkOutput("b2b_second_busy", {31'd0, busy}, 32'd1);
         checkOutput("b2b_hi_mid", HI, m_hi);
         checkOutput("b2b_lo_mid", LO, m_lo);
         @(posedge clk);
         @(negedge clk);
      end
      m_hi = 32'd2;
      m_lo = 32'd14;
      checkOutput("b2b_busy_done", {31'd0, busy}, 32'd0);
      checkOutput("b2b_hi_final", HI, m_hi);
      checkOutput("b2b_lo_final", LO, m_lo);

      $display("[TB] randomized operations");
      for (int k = 0; k < 40; k++) begin
         op = 4'($urandom_range(0, 15));
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 20);
         if ((op == 4'd3 || op == 4'd4) && $urandom_range(0, 7) == 0) b = 32'd0;
         if (op == 4'd3 && $urandom_range(0, 7) == 0) begin
            a = 32'h8000_0000;
            b = 32'hFFFF_FFFF;
         end
         if (op >= 4'd1 && op <= 4'd4) runOp(op, a, b, 1'($urandom_range(0, 1)));
         else if (op == 4'd7 || op == 4'd8) doMove(op, a);
         else doRead(op, 1'($urandom_range(0, 1)));
      end

      $display("[TB] reset during a divide");
      applyStimulus(1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2);
      @(posedge clk);
      @(negedge clk);
      applyStimulus(1'b0, 4'd0, 32'd0, 32'd0);
      for (int i = 1; i < 3; i++) begin
         checkOutput("pre_reset_busy", {31'd0, busy}, 32'd1);
         @(posedge clk);
         @(negedge clk);
      end
      #2 reset = 1'b1;
      #1;
      m_hi = 32'd0;
      m_lo = 32'd0;
      checkOutput("async_reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("async_reset_hi", HI, m_hi);
      checkOutput("async_reset_lo", LO, m_lo);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < DC; i++) begin
         @(posedge clk);
         @(negedge clk);
         checkOutput("post_reset_busy", {31'd0, busy}, 32'd0);
         checkOutput("post_reset_hi", HI, m_hi);
         checkOutput("post_reset_lo", LO, m_lo);
      end
      runOp(4'd1, 32'd3, 32'd4, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit in the E stage of the five-stage pipeline. Executes mult/multu/div/divu with fixed multi-cycle latency, holds the architectural HI/LO registers, and serves mthi/mtlo/mfhi/mflo. mfhi/mflo results travel E→M→W and are written to the register file like any ALU result. `busy` and `start` drive the hazard unit's stall decision.

## Interface

- `MULT_CYCLES`, 5, busy cycles for mult/multu (≥1)
- `DIV_CYCLES`, 10, busy cycles for div/divu (≥1)

- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `start`  in  1  E-stage instruction is a valid mult/multu/div/divu (not a bubble)
- `mdu_op`  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; others = none
- `A`  in  32  rs operand (forwarded)
- `B`  in  32  rt operand (forwarded)
- `busy`  out  1  operation in flight
- `HI`  out  32  architectural HI
- `LO`  out  32  architectural LO
- `mdu_rd`  out  32  HI if op=mfhi, LO if op=mflo, else 0 (combinational)

## Operation

- State: `HI`, `LO`, temp `hi_t`/`lo_t`, down-counter `cnt` (width fits max(MULT_CYCLES, DIV_CYCLES)), flag `commit_en`.
- Two states implied by `cnt`: IDLE (`cnt`=0) and RUN (`cnt`≠0); `busy` = (`cnt`≠0), registered.
- IDLE + `start` with op 1–4: compute result from `A`,`B` at that edge into `hi_t`/`lo_t`; load `cnt` with MULT_CYCLES or DIV_CYCLES; enter RUN.
- RUN: `cnt` decrements each edge; on the edge where `cnt`=1, if `commit_en` copy `hi_t`/`lo_t` to `HI`/`LO`; `cnt`→0, IDLE.
- `start` with op 1–4 while `busy`: ignored (hazard unit must prevent it).
- Arithmetic:
  - mult: {HI,LO} = signed 32×32 → 64-bit product.
  - multu: unsigned 64-bit product.
  - div: LO = signed quotient truncated toward zero, HI = remainder with dividend's sign.
  - divu: unsigned quotient/remainder.
  - Overflow case 0x80000000 / 0xFFFFFFFF (div): LO = 0x80000000, HI = 0.
- Divide by zero (`B`=0, div/divu): full DIV_CYCLES busy period, `commit_en`=0, HI/LO unchanged.
- mthi/mtlo (op 7/8): write `A` to HI/LO at the edge, only when not `busy`; ignored while `busy`. `start` is not required.
- mfhi/mflo: `mdu_rd` reflects current architectural HI/LO. During `busy` it returns the old value (hazard unit stalls).
- Reset: `HI`, `LO`, `hi_t`, `lo_t`, `cnt`, `commit_en` → 0; `busy` → 0. An in-flight operation is discarded and never commits.

## Timing

- `start` sampled at edge E0. `busy`=1 in the N cycles after E0 (N = MULT_CYCLES or DIV_CYCLES). HI/LO are updated at edge EN; `busy`=0 from the same edge.
- A back-to-back `start` is accepted at EN (the commit edge) as a fresh IDLE start: its commit at EN is the previous operation's, and `cnt` reloads.
- The hazard unit stalls D-stage MDU-class instructions (ops 1–8) while (`start` | `busy`).
- mthi/mtlo take effect at the edge they are presented; mfhi in the next cycle reads the new value.
- `mdu_rd`, `HI`, `LO` have no combinational path from `start`.

## Test plan

- mult A=0xFFFFFFFF, B=0x00000002 → `busy` high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles; HI/LO hold old values during `busy`.
- div A=0xFFFFFFF9 (−7), B=2 → 10 busy cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 100/7 → LO=14, HI=2.
- With HI=0x11, LO=0x22 preset, divu B=0 → `busy` 10 cycles; HI=0x11, LO=0x22 unchanged.
- mthi A=0x12345678, then mfhi → `mdu_rd`=0x12345678. Start mult, issue mtlo A=0xDEAD during `busy` → ignored; LO ends equal to the product.
- Start div, assert `reset` mid-cycle at busy cycle 3 → `busy`, HI, LO = 0 immediately, with no commit afterwards. A subsequent mult 3×4 → LO=12, HI=0.
